// File: rtl/sd_sector_responder.sv
// sd_sector_responder: serves 512-byte sector transfers between an SD-style core buffer
// interface and a 16-bit backing store at {lba[7:0], word}.
// Optional build macro SD_RESP_BOUNDS_EN: sectors with lba >= MAX_LBA complete the full
// handshake, but the backing store is never touched and read data is 16'hFFFF.
module sd_sector_responder #(
  parameter int unsigned ACK_DELAY = 4,   // 1..15
  parameter int unsigned MAX_LBA   = 256
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [7:0]  sd_buff_addr,
  output logic [15:0] sd_buff_dout,
  output logic        sd_buff_wr,
  input  logic [15:0] sd_buff_din,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_q,
  output logic        mem_wr,
  output logic [15:0] mem_d,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StDelay, StXfer, StDrain, StGap} state_e;

  localparam logic [3:0] DlyLoad = 4'(ACK_DELAY - 1);

  state_e      state_q, state_d;
  logic [3:0]  dly_q, dly_d;
  logic [8:0]  wcnt_q, wcnt_d;
  logic        pend_q, pend_d;   // a word was issued last cycle and retires this cycle
  logic [7:0]  prev_q, prev_d;   // index of that pending word
  logic [31:0] lba_q, lba_d;
  logic        rd_q, rd_d;
  logic        oob;

`ifdef SD_RESP_BOUNDS_EN
  assign oob = (lba_q >= 32'(MAX_LBA));
`else
  logic unused_cfg;
  assign oob        = 1'b0;
  // Upper lba bits alias onto the 256-sector store.
  assign unused_cfg = ^{lba_q[31:8], 32'(MAX_LBA)};
`endif

  // State and transfer bookkeeping registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      dly_q   <= '0;
      wcnt_q  <= '0;
      pend_q  <= 1'b0;
      prev_q  <= '0;
      lba_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      wcnt_q  <= wcnt_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state logic: latch request, count delay, walk 256 words, drain, gap.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    wcnt_d  = wcnt_q;
    pend_d  = 1'b0;
    prev_d  = prev_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    unique case (state_q)
      StIdle: begin
        if (sd_rd || sd_wr) begin
          lba_d   = sd_lba;
          rd_d    = sd_rd;  // read wins when both are requested
          dly_d   = DlyLoad;
          state_d = StDelay;
        end
      end
      StDelay: begin
        if (dly_q == 4'd0) begin
          wcnt_d  = '0;
          state_d = StXfer;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      StXfer: begin
        pend_d = 1'b1;
        prev_d = wcnt_q[7:0];
        wcnt_d = wcnt_q + 9'd1;
        if (wcnt_q == 9'd255) state_d = StDrain;
      end
      StDrain: begin
        state_d = StGap;
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode: issue word k in XFER, retire it one cycle later.
  always_comb begin
    sd_ack       = (state_q == StXfer) || (state_q == StDrain);
    busy         = (state_q != StIdle);
    mem_rd       = (state_q == StXfer) && rd_q && !oob;
    mem_wr       = pend_q && !rd_q && !oob;
    sd_buff_wr   = pend_q && rd_q;
    sd_buff_dout = '0;
    mem_d        = '0;
    sd_buff_addr = '0;
    mem_addr     = '0;
    if (sd_buff_wr) begin
      sd_buff_dout = oob ? 16'hFFFF : mem_q;
      sd_buff_addr = prev_q;
    end
    if (!rd_q && (state_q == StXfer)) sd_buff_addr = wcnt_q[7:0];
    if (mem_wr) begin
      mem_d    = sd_buff_din;
      mem_addr = {lba_q[7:0], prev_q};
    end
    if (mem_rd) mem_addr = {lba_q[7:0], wcnt_q[7:0]};
  end

endmodule

// File: tb/tb_sd_sector_responder.sv
// Self-checking bench for sd_sector_responder: table vectors, randomized transfers against a
// sector-level reference model, plus back-to-back and mid-transfer reset sequences.
module tb_sd_sector_responder;

  localparam int unsigned AckDelay = 4;
  localparam int unsigned MaxLba   = 256;
`ifdef SD_RESP_BOUNDS_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] sd_lba = '0;
  logic        sd_rd = 1'b0;
  logic        sd_wr = 1'b0;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_din = '0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_q = '0;
  logic        mem_wr;
  logic [15:0] mem_d;
  logic        busy;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [15:0] rd_salt  = '0;
  logic [15:0] din_salt = '0;

  sd_sector_responder #(
    .ACK_DELAY(AckDelay),
    .MAX_LBA  (MaxLba)
  ) dut (
    .clk_sys     (clk),
    .reset_n     (reset_n),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_q       (mem_q),
    .mem_wr      (mem_wr),
    .mem_d       (mem_d),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_val(input logic [15:0] a);
    return a ^ rd_salt;
  endfunction

  function automatic logic [15:0] din_val(input logic [7:0] a);
    return (~{8'h00, a}) ^ din_salt;
  endfunction

  // Backing store (synchronous read) and core buffer (din one cycle after addr).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_q <= rd_val(mem_addr);
    sd_buff_din <= din_val(sd_buff_addr);
  end

  // Transfer monitor: records every strobe of the current transfer.
  int nbw, nmw, nmr, nboth, ack_len, busy_len, lat_cyc, ack_cyc;
  logic busy_p = 1'b0;
  logic ack_p  = 1'b0;
  logic [7:0]  cap_baddr [256];
  logic [15:0] cap_bdout [256];
  logic [15:0] cap_raddr [256];
  logic [15:0] cap_waddr [256];
  logic [15:0] cap_wd    [256];

  always @(negedge clk) begin
    if (busy && !busy_p) begin
      nbw = 0; nmw = 0; nmr = 0; nboth = 0;
      ack_len = 0; busy_len = 0; lat_cyc = cyc; ack_cyc = -1000;
    end
    if (busy) busy_len++;
    if (sd_ack) ack_len++;
    if (sd_ack && !ack_p) ack_cyc = cyc;
    if (sd_buff_wr && mem_wr) nboth++;
    if (sd_buff_wr) begin
      if (nbw < 256) begin
        cap_baddr[nbw] = sd_buff_addr;
        cap_bdout[nbw] = sd_buff_dout;
      end
      nbw++;
    end
    if (mem_rd) begin
      if (nmr < 256) cap_raddr[nmr] = mem_addr;
      nmr++;
    end
    if (mem_wr) begin
      if (nmw < 256) begin
        cap_waddr[nmw] = mem_addr;
        cap_wd[nmw]    = mem_d;
      end
      nmw++;
    end
    busy_p = busy;
    ack_p  = sd_ack;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_busy(input logic level, input int bound);
    int n = 0;
    while (busy !== level && n < bound) begin
      tick();
      n++;
    end
    if (busy !== level) chk("busy_wait_timeout", {63'd0, busy}, {63'd0, level});
  endtask

  // Reference model: a sector transfer seen as a whole.
  task automatic check_xfer(input string tag, input logic is_read, input logic [31:0] lba);
    logic       oob;
    logic [7:0] lo;
    int         bad;
    oob = BoundsEn && (lba >= MaxLba);
    lo  = lba[7:0];
    bad = 0;
    chk({tag, "_ack_latency"}, 64'(ack_cyc - lat_cyc), 64'(AckDelay));
    chk({tag, "_ack_len"}, 64'(ack_len), 64'd257);
    chk({tag, "_busy_len"}, 64'(busy_len), 64'(AckDelay + 258));
    chk({tag, "_n_buff_wr"}, 64'(nbw), is_read ? 64'd256 : 64'd0);
    chk({tag, "_n_mem_rd"}, 64'(nmr), (is_read && !oob) ? 64'd256 : 64'd0);
    chk({tag, "_n_mem_wr"}, 64'(nmw), (!is_read && !oob) ? 64'd256 : 64'd0);
    chk({tag, "_strobe_overlap"}, 64'(nboth), 64'd0);
    for (int k = 0; k < 256; k++) begin
      if (is_read && nbw == 256) begin
        if (cap_baddr[k] !== 8'(k)) bad++;
        if (cap_bdout[k] !== (oob ? 16'hFFFF : rd_val({lo, 8'(k)}))) bad++;
        if (!oob && nmr == 256 && cap_raddr[k] !== {lo, 8'(k)}) bad++;
      end
      if (!is_read && !oob && nmw == 256) begin
        if (cap_waddr[k] !== {lo, 8'(k)}) bad++;
        if (cap_wd[k] !== din_val(8'(k))) bad++;
      end
    end
    chk({tag, "_word_errors"}, 64'(bad), 64'd0);
  endtask

  task automatic run_xfer(input logic rd, input logic wr, input logic [31:0] lba,
                          input bit noise);
    sd_rd  = rd;
    sd_wr  = wr;
    sd_lba = lba;
    wait_busy(1'b1, 4);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    if (noise) begin
      for (int i = 0; i < 150; i++) begin
        tick();
        sd_rd  = 1'($urandom_range(0, 1));
        sd_wr  = 1'($urandom_range(0, 1));
        sd_lba = $urandom;
      end
      sd_rd = 1'b0;
      sd_wr = 1'b0;
    end
    wait_busy(1'b0, 400);
  endtask

  function automatic logic [63:0] out_vec();
    return {3'd0, sd_ack, sd_buff_wr, mem_rd, mem_wr, busy, sd_buff_addr, sd_buff_dout,
            mem_addr, mem_d};
  endfunction

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    logic        exp_read;
    int          exp_nbw;
    int          exp_nmw;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int snap_b, snap_r, idle;
    logic r, w;
    logic [31:0] l;

    vecs[0] = '{1'b1, 1'b0, 32'd3,   1'b1, 256, 0};
    vecs[1] = '{1'b0, 1'b1, 32'd5,   1'b0, 0,   256};
    vecs[2] = '{1'b1, 1'b1, 32'd7,   1'b1, 256, 0};
    vecs[3] = '{1'b0, 1'b1, 32'd200, 1'b0, 0,   256};
    vecs[4] = '{1'b1, 1'b0, 32'd255, 1'b1, 256, 0};

    tick();
    chk("reset_outputs", out_vec(), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", out_vec(), 64'd0);

    foreach (vecs[i]) begin
      rd_salt  = '0;
      din_salt = '0;
      run_xfer(vecs[i].rd, vecs[i].wr, vecs[i].lba, 1'b0);
      check_xfer($sformatf("vec%0d", i), vecs[i].exp_read, vecs[i].lba);
      chk($sformatf("vec%0d_tbl_nbw", i), 64'(nbw), 64'(vecs[i].exp_nbw));
      chk($sformatf("vec%0d_tbl_nmw", i), 64'(nmw), 64'(vecs[i].exp_nmw));
      tick();
    end

    for (int t = 0; t < 10; t++) begin
      rd_salt  = 16'($urandom);
      din_salt = 16'($urandom);
      r = 1'($urandom_range(0, 1));
      w = r ? 1'($urandom_range(0, 1)) : 1'b1;
      l = $urandom;
      if (t % 2 == 0) l = {24'd0, l[7:0]};
      run_xfer(r, w, l, 1'b1);
      check_xfer($sformatf("rand%0d", t), r, l);
      tick();
    end

    // Held request: one gap cycle, then a new transfer with the resampled lba.
    rd_salt = 16'h5A5A;
    sd_rd   = 1'b1;
    sd_lba  = 32'd10;
    wait_busy(1'b1, 4);
    tick();
    sd_lba = 32'd11;
    wait_busy(1'b0, 400);
    check_xfer("b2b_first", 1'b1, 32'd10);
    idle = 1;
    tick();
    while (!busy && idle < 5) begin
      idle++;
      tick();
    end
    chk("b2b_idle_cycles", 64'(idle), 64'd1);
    sd_rd = 1'b0;
    wait_busy(1'b0, 400);
    check_xfer("b2b_second", 1'b1, 32'd11);
    tick();

    // Reset during word ~100 of a read.
    rd_salt = '0;
    sd_rd   = 1'b1;
    sd_lba  = 32'd3;
    wait_busy(1'b1, 4);
    sd_rd = 1'b0;
    for (int i = 0; i < 400 && nbw < 100; i++) tick();
    chk("abort_reached_word100", 64'(nbw), 64'd100);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs_zero", out_vec(), 64'd0);
    snap_b = nbw;
    snap_r = nmr;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("abort_no_more_buff_wr", 64'(nbw), 64'(snap_b));
    chk("abort_no_more_mem_rd", 64'(nmr), 64'(snap_r));
    chk("abort_idle", out_vec(), 64'd0);

    // Request present at reset release is taken on the first edge.
    reset_n = 1'b0;
    tick();
    din_salt = '0;
    reset_n  = 1'b1;
    sd_wr    = 1'b1;
    sd_lba   = 32'd9;
    tick();
    chk("first_edge_accept", {63'd0, busy}, 64'd1);
    sd_wr = 1'b0;
    wait_busy(1'b0, 400);
    check_xfer("post_reset", 1'b0, 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_sector_responder.md
SD_SECTOR_RESPONDER -- requirements
Module: sd_sector_responder

Interface
REQ-001 SHALL have parameter ACK_DELAY, default 4: clk_sys cycles from request latch to sd_ack rise (range 1..15).
REQ-002 SHALL have parameter MAX_LBA, default 256: number of valid sectors (used only under configuration macro).
REQ-003 clk_sys  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 sd_lba  in  32  sector number, sampled at request latch.
REQ-006 sd_rd  in  1  level request: sector to core.
REQ-007 sd_wr  in  1  level request: core to sector.
REQ-008 sd_ack  out  1  high for the whole transfer window.
REQ-009 sd_buff_addr  out  8  16-bit word index within the 512-byte sector.
REQ-010 sd_buff_dout  out  16  read data to core.
REQ-011 sd_buff_wr  out  1  one-cycle strobe: sd_buff_dout valid at sd_buff_addr.
REQ-012 sd_buff_din  in  16  write data from core; valid 1 cycle after sd_buff_addr.
REQ-013 mem_addr  out  16  backing-store word address = {sd_lba[7:0], word index}.
REQ-014 mem_rd  out  1  read strobe; mem_q valid the following cycle.
REQ-015 mem_q  in  16  backing-store read data.
REQ-016 mem_wr  out  1  write strobe with mem_d at mem_addr.
REQ-017 mem_d  out  16  backing-store write data.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 States SHALL be IDLE, DELAY, XFER, DRAIN, GAP.
REQ-020 IDLE: on sd_rd|sd_wr, SHALL latch sd_lba and direction (sd_rd wins if both set), load delay counter, go to DELAY.
REQ-021 DELAY: after ACK_DELAY cycles, SHALL raise sd_ack, clear word counter, go to XFER.
REQ-022 Read XFER: cycle k (k=0..255) SHALL assert mem_rd with word k; cycle k+1 SHALL assert sd_buff_wr with sd_buff_addr=k, sd_buff_dout=mem_q.
REQ-023 Write XFER: cycle k SHALL drive sd_buff_addr=k; cycle k+1 SHALL assert mem_wr with word k, mem_d=sd_buff_din.
REQ-024 Word counter SHALL be 9 bits; after word 255 is issued, SHALL go to DRAIN for exactly one cycle to retire the last pipelined word; no address wrap to 0 SHALL be issued.
REQ-025 DRAIN SHALL end with sd_ack low on the next cycle; transfer = 257 cycles with sd_ack high.
REQ-026 GAP: SHALL hold one cycle, ignoring requests, then return to IDLE; a request still high in IDLE is a new request.
REQ-027 sd_rd/sd_wr changes during DELAY/XFER/DRAIN SHALL be ignored; direction and lba fixed per transfer.
REQ-028 sd_buff_wr and mem_wr SHALL never be asserted in the same cycle; at most one strobe of each per word.

Reset
REQ-029 On reset_n low, immediately: state IDLE, sd_ack 0, sd_buff_wr 0, mem_rd 0, mem_wr 0, busy 0, sd_buff_addr 0, sd_buff_dout 0, mem_addr 0, mem_d 0, counters 0.
REQ-030 Reset mid-transfer SHALL abort without completing remaining words; words already strobed remain written.
REQ-031 After reset_n release, first request SHALL be accepted on the first rising edge with reset_n high.

Configuration
REQ-032 Macro SD_RESP_BOUNDS_EN: when defined, a request with latched lba >= MAX_LBA SHALL run the full handshake and timing but issue no mem_rd/mem_wr; read data SHALL be 16'hFFFF.
REQ-033 Without SD_RESP_BOUNDS_EN: no check; lba[7:0] SHALL be used, aliasing higher lba bits.

Verification
REQ-034 sd_rd=1, lba=3, mem preloaded word=addr -> sd_ack rises 4 cycles after latch, 256 sd_buff_wr, addr 0..255, dout 16'h0300..16'h03FF, sd_ack high 257 cycles.
REQ-035 sd_wr=1, lba=5, core returns din=~addr -> 256 mem_wr, mem_addr 16'h0500..16'h05FF, mem_d 16'hFFFF..16'hFF00.
REQ-036 sd_rd and sd_wr both high -> read transfer performed, zero mem_wr.
REQ-037 Initiator keeps sd_rd high after transfer -> GAP one cycle, second transfer latched in IDLE, lba resampled.
REQ-038 reset_n low at word 100 of a read -> sd_ack and all strobes 0 same cycle, state IDLE, no further strobes.
REQ-039 With SD_RESP_BOUNDS_EN, MAX_LBA=16, read lba=20 -> 256 sd_buff_wr of 16'hFFFF, mem_rd never asserted.
